fpu_share_arbiter: RTL and testbench

//  Shares one pipelined FP unit (mult/adder wrapper, ops on DATA_W floats) among NUM_REQ processing elements.
//  - Grants requesters round-robin and issues one op per cycle into the FPU.
//  - Carries the requester tag alongside each op through the FPU latency.
//  - Returns each result and its flags to the requester that issued it.
//  - Sits between the PE array and the FPU inside sparse_matrix_coprocessor.

---
 rtl/fpu_arb_pkg.sv | 38 +++
 rtl/fpu_share_arbiter_rr_grant.sv | 61 ++++++
 rtl/fpu_share_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_fpu_share_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : fpu_arb_pkg
// Brief  : Shared types and constants for the FPU share arbiter.
//          FLAG_W       - width of the FPU status flag vector
//          fpu_op_e     - FPU operation select (MUL / ADD)
//          fpu_flags_t  - {nan, zero, underflow, overflow}
//          wrap_idx()   - round-robin index helper: (base + off) mod n
// Rev    : 1.0 - initial release
// ============================================================================
package fpu_arb_pkg;

    localparam int FLAG_W = 4;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_ADD = 1'b1
    } fpu_op_e;

    typedef struct packed {
        logic nan;
        logic zero;
        logic underflow;
        logic overflow;
    } fpu_flags_t;

    // base < n and off < n, so a single conditional subtract replaces a modulo.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_share_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module : rr_grant
// Brief  : Round-robin grant generator. Owns the rotating priority pointer.
//          clk, reset  - clock, synchronous active-high reset (ptr -> 0)
//          enable      - grants allowed this cycle (otherwise grant = 0)
//          req         - per-requester request vector
//          grant       - one-hot grant, combinational from req
//          grant_idx   - binary index of the granted requester
// Rev    : 1.0 - initial release
// ============================================================================
module rr_grant
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [TAG_W-1:0]   grant_idx
);

    logic [TAG_W-1:0] ptr_q;
    logic [TAG_W-1:0] ptr_d;

    // Scan offsets from the farthest to the nearest so the requester closest
    // to (at or after) the pointer is the last assignment and therefore wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (enable) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req[wrap_idx(int'(ptr_q), i, NUM_REQ)]) begin
                    grant     = '0;
                    grant[wrap_idx(int'(ptr_q), i, NUM_REQ)] = 1'b1;
                    grant_idx = TAG_W'(wrap_idx(int'(ptr_q), i, NUM_REQ));
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (|grant) begin
            ptr_d = TAG_W'(wrap_idx(int'(grant_idx), 1, NUM_REQ));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fpu_share_arbiter
// Brief  : Shares one pipelined FP unit among NUM_REQ requesters. Grants
//          round-robin, issues one op per cycle, carries the requester tag
//          through the FPU latency and returns result + flags to the issuer.
// Ports  : clk/reset (sync, active-high), stall (freezes FPU + tag pipe)
//          req_valid/req_ready/req_op/req_a/req_b  - requester side
//          rsp_valid/rsp_data/rsp_flags            - one-hot response strobe
//          busy                                    - ops in issue reg or pipe
//          fpu_clk_en/fpu_op/fpu_dataa/fpu_datab   - FPU drive
//          fpu_result/fpu_flags                    - FPU return
//          sticky_flags/flag_clr                   - per-requester flag sticky
// Config : FPU_ARB_STICKY_FLAGS_EN enables sticky_flags accumulation; when
//          undefined sticky_flags is 0 and flag_clr is ignored.
// Rev    : 1.0 - initial release
// ============================================================================
module fpu_share_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int FPU_LAT = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_op,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [FLAG_W-1:0]           rsp_flags,
    output logic                        busy,
    output logic                        fpu_clk_en,
    output logic                        fpu_op,
    output logic [DATA_W-1:0]           fpu_dataa,
    output logic [DATA_W-1:0]           fpu_datab,
    input  logic [DATA_W-1:0]           fpu_result,
    input  logic [FLAG_W-1:0]           fpu_flags,
    output logic [NUM_REQ*FLAG_W-1:0]   sticky_flags,
    input  logic [NUM_REQ-1:0]          flag_clr
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                      adv;
    logic [NUM_REQ-1:0]        grant;
    logic [TAG_W-1:0]          grant_idx;

    // Issue register
    logic                      iss_valid_q, iss_valid_d;
    logic [TAG_W-1:0]          iss_tag_q,   iss_tag_d;
    fpu_op_e                   iss_op_q,    iss_op_d;
    logic [DATA_W-1:0]         iss_a_q,     iss_a_d;
    logic [DATA_W-1:0]         iss_b_q,     iss_b_d;

    // Tag pipeline, stage FPU_LAT-1 lines up with fpu_result
    logic [FPU_LAT-1:0]             pipe_valid_q, pipe_valid_d;
    logic [FPU_LAT-1:0][TAG_W-1:0]  pipe_tag_q,   pipe_tag_d;

    // Response registers
    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]         rsp_data_q,  rsp_data_d;
    fpu_flags_t                rsp_flags_q, rsp_flags_d;

    assign adv = ~stall;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W)
    ) u_rr_grant (
        .clk       (clk),
        .reset     (reset),
        .enable    (~reset & ~stall),
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_tag_d   = iss_tag_q;
        iss_op_d    = iss_op_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        if (adv) begin
            iss_valid_d = |grant;
            if (|grant) begin
                iss_tag_d = grant_idx;
                iss_op_d  = fpu_op_e'(req_op[grant_idx]);
                iss_a_d   = req_a[int'(grant_idx)*DATA_W +: DATA_W];
                iss_b_d   = req_b[int'(grant_idx)*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        pipe_valid_d = pipe_valid_q;
        pipe_tag_d   = pipe_tag_q;
        if (adv) begin
            pipe_valid_d[0] = iss_valid_q;
            pipe_tag_d[0]   = iss_tag_q;
            for (int i = 1; i < FPU_LAT; i++) begin
                pipe_valid_d[i] = pipe_valid_q[i-1];
                pipe_tag_d[i]   = pipe_tag_q[i-1];
            end
        end
    end

    // rsp_valid is a single-cycle strobe: it falls back to zero on the next
    // edge regardless of stall. Data/flags hold until the next response.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        if (adv && pipe_valid_q[FPU_LAT-1]) begin
            rsp_valid_d = NUM_REQ'(1) << pipe_tag_q[FPU_LAT-1];
            rsp_data_d  = fpu_result;
            rsp_flags_d = fpu_flags_t'(fpu_flags);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_valid_q  <= 1'b0;
            iss_tag_q    <= '0;
            iss_op_q     <= OP_MUL;
            iss_a_q      <= '0;
            iss_b_q      <= '0;
            pipe_valid_q <= '0;
            pipe_tag_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_flags_q  <= '0;
        end else begin
            iss_valid_q  <= iss_valid_d;
            iss_tag_q    <= iss_tag_d;
            iss_op_q     <= iss_op_d;
            iss_a_q      <= iss_a_d;
            iss_b_q      <= iss_b_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_tag_q   <= pipe_tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign req_ready  = grant;
    assign fpu_clk_en = adv;
    assign fpu_op     = iss_op_q;
    assign fpu_dataa  = iss_a_q;
    assign fpu_datab  = iss_b_q;
    assign busy       = iss_valid_q | (|pipe_valid_q);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_flags  = rsp_flags_q;

`ifdef FPU_ARB_STICKY_FLAGS_EN
    logic [NUM_REQ-1:0][FLAG_W-1:0] sticky_q, sticky_d;

    // Clear first, then OR in the new response so a coincident set survives.
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_sticky
        always_comb begin
            sticky_d[r] = flag_clr[r] ? '0 : sticky_q[r];
            if (rsp_valid_q[r]) begin
                sticky_d[r] = sticky_d[r] | rsp_flags_q;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                sticky_q[r] <= '0;
            end else begin
                sticky_q[r] <= sticky_d[r];
            end
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_flag_clr;
    assign unused_flag_clr = ^flag_clr;
    assign sticky_flags    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_fpu_share_arbiter
// Brief  : Directed self-checking bench for fpu_share_arbiter with a small
//          behavioural 5-deep FPU model (enabled by fpu_clk_en).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fpu_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int FPU_LAT = 5;
`ifdef FPU_ARB_STICKY_FLAGS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        stall;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          req_op;
    logic [NUM_REQ*DATA_W-1:0]   req_a;
    logic [NUM_REQ*DATA_W-1:0]   req_b;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [DATA_W-1:0]           rsp_data;
    logic [3:0]                  rsp_flags;
    logic                        busy;
    logic                        fpu_clk_en;
    logic                        fpu_op;
    logic [DATA_W-1:0]           fpu_dataa;
    logic [DATA_W-1:0]           fpu_datab;
    logic [DATA_W-1:0]           fpu_result;
    logic [3:0]                  fpu_flags;
    logic [NUM_REQ*4-1:0]        sticky_flags;
    logic [NUM_REQ-1:0]          flag_clr;

    int checks = 0;
    int errors = 0;

    fpu_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .FPU_LAT (FPU_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_flags    (rsp_flags),
        .busy         (busy),
        .fpu_clk_en   (fpu_clk_en),
        .fpu_op       (fpu_op),
        .fpu_dataa    (fpu_dataa),
        .fpu_datab    (fpu_datab),
        .fpu_result   (fpu_result),
        .fpu_flags    (fpu_flags),
        .sticky_flags (sticky_flags),
        .flag_clr     (flag_clr)
    );

    always #5 clk = ~clk;

    // Stand-in FPU: 2.0*3.0 gives the real half-precision product, every other
    // op returns a+b+op; flags come from b[3:0] so tests can pick them.
    function automatic logic [DATA_W-1:0] fpu_model(input logic op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        if (!op && a == 16'h4000 && b == 16'h4200) return 16'h4600;
        return a + b + {{(DATA_W-1){1'b0}}, op};
    endfunction

    logic [DATA_W-1:0] pr [FPU_LAT];
    logic [3:0]        pf [FPU_LAT];

    always @(posedge clk) begin
        if (fpu_clk_en) begin
            pr[0] <= fpu_model(fpu_op, fpu_dataa, fpu_datab);
            pf[0] <= fpu_datab[3:0];
            for (int i = 1; i < FPU_LAT; i++) begin
                pr[i] <= pr[i-1];
                pf[i] <= pf[i-1];
            end
        end
    end

    assign fpu_result = pr[FPU_LAT-1];
    assign fpu_flags  = pf[FPU_LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        stall     = 1'b0;
        req_valid = '0;
        flag_clr  = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int r, input logic op, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b);
        req_op[r]               = op;
        req_a[r*DATA_W +: DATA_W] = a;
        req_b[r*DATA_W +: DATA_W] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        flag_clr  = '0;
        tick();
        tick();

        // Reset state, including a gated grant while reset is high
        req_valid = 4'b1111;
        #1;
        chk("rst_ready",  64'(req_ready),    64'h0);
        chk("rst_rspv",   64'(rsp_valid),    64'h0);
        chk("rst_rspd",   64'(rsp_data),     64'h0);
        chk("rst_flags",  64'(rsp_flags),    64'h0);
        chk("rst_busy",   64'(busy),         64'h0);
        chk("rst_sticky", 64'(sticky_flags), 64'h0);
        req_valid = '0;
        reset     = 1'b0;
        tick();

        // 1. Single MUL 2.0*3.0 from requester 0
        do_reset();
        for (int k = 0; k < 10; k++) begin
            req_valid = (k == 0) ? 4'b0001 : 4'b0000;
            set_req(0, 1'b0, 16'h4000, 16'h4200);
            #1;
            if (k == 0) chk("t1_ready", 64'(req_ready), 64'h1);
            if (k == 1) begin
                chk("t1_busy",  64'(busy),      64'h1);
                chk("t1_fpuop", 64'(fpu_op),    64'h0);
                chk("t1_fpua",  64'(fpu_dataa), 64'h4000);
                chk("t1_fpub",  64'(fpu_datab), 64'h4200);
            end
            chk("t1_rspv", 64'(rsp_valid), (k == 7) ? 64'h1 : 64'h0);
            if (k == 7) begin
                chk("t1_rspd",  64'(rsp_data),  64'h4600);
                chk("t1_flags", 64'(rsp_flags), 64'h0);
            end
            if (k == 8) chk("t1_idle", 64'(busy), 64'h0);
            tick();
        end

        // 2. All four valid for 8 cycles: strict rotation, responses 7 later
        do_reset();
        for (int r = 0; r < NUM_REQ; r++) set_req(r, 1'b1, 16'(r * 16'h1000 + 1), 16'h0010);
        for (int k = 0; k < 17; k++) begin
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            chk("t2_ready", 64'(req_ready), (k < 8) ? 64'(4'b0001 << (k % 4)) : 64'h0);
            chk("t2_rspv", 64'(rsp_valid),
                (k >= 7 && k < 15) ? 64'(4'b0001 << ((k - 7) % 4)) : 64'h0);
            if (k >= 7 && k < 15) chk("t2_rspd", 64'(rsp_data), 64'(((k - 7) % 4) * 16'h1000 + 16'h12));
            tick();
        end

        // 3. Three ops from requester 0, stall 3 cycles mid-flight
        do_reset();
        for (int k = 0; k < 15; k++) begin
            req_valid = (k < 6) ? 4'b0001 : 4'b0000;
            stall     = (k >= 3 && k < 6);
            set_req(0, 1'b0, 16'(16'h0100 + k), 16'h0000);
            #1;
            chk("t3_ready", 64'(req_ready), (k < 3) ? 64'h1 : 64'h0);
            if (k == 2 || k == 4) chk("t3_clken", 64'(fpu_clk_en), (k == 2) ? 64'h1 : 64'h0);
            chk("t3_rspv", 64'(rsp_valid), (k >= 10 && k < 13) ? 64'h1 : 64'h0);
            if (k >= 10 && k < 13) chk("t3_rspd", 64'(rsp_data), 64'(16'h0100 + (k - 10)));
            tick();
        end
        stall = 1'b0;

        // 4. Reset with three ops in flight discards them; pointer back to 0
        do_reset();
        for (int r = 0; r < NUM_REQ; r++) set_req(r, 1'b0, 16'h0300, 16'h0000);
        for (int k = 0; k < 13; k++) begin
            req_valid = (k < 5) ? 4'b1111 : 4'b0000;
            reset     = (k == 3);
            #1;
            if (k == 3) chk("t4_rst_ready", 64'(req_ready), 64'h0);
            if (k == 4) begin
                chk("t4_busy",  64'(busy),      64'h0);
                chk("t4_ready", 64'(req_ready), 64'h1);
                chk("t4_rspd",  64'(rsp_data),  64'h0);
            end
            if (k >= 4) chk("t4_rspv", 64'(rsp_valid), (k == 11) ? 64'h1 : 64'h0);
            tick();
        end
        reset = 1'b0;

        // 5. ADD with overflow flag for requester 2; sticky set/clear
        do_reset();
        set_req(2, 1'b1, 16'h3C00, 16'h3C01);
        for (int k = 0; k < 20; k++) begin
            req_valid = (k == 0 || k == 10) ? 4'b0100 : 4'b0000;
            flag_clr  = (k == 9 || k == 17) ? 4'b0100 : 4'b0000;
            #1;
            if (k == 0) chk("t5_ready", 64'(req_ready), 64'h4);
            chk("t5_rspv", 64'(rsp_valid), (k == 7 || k == 17) ? 64'h4 : 64'h0);
            if (k == 7 || k == 17) begin
                chk("t5_rspd",  64'(rsp_data),  64'h7802);
                chk("t5_flags", 64'(rsp_flags), 64'h1);
            end
            if (k >= 8) chk("t5_sticky", 64'(sticky_flags),
                            (STICKY && (k < 10 || k >= 18)) ? 64'h100 : 64'h0);
            tick();
        end
        flag_clr = '0;

        // 6. Pointer moved to 3, then only requester 1 valid for 5 cycles
        do_reset();
        set_req(2, 1'b0, 16'h0500, 16'h0000);
        set_req(1, 1'b0, 16'h0600, 16'h0000);
        for (int k = 0; k < 15; k++) begin
            req_valid = (k == 0) ? 4'b0100 : ((k < 6) ? 4'b0010 : 4'b0000);
            #1;
            chk("t6_ready", 64'(req_ready), (k == 0) ? 64'h4 : ((k < 6) ? 64'h2 : 64'h0));
            chk("t6_rspv", 64'(rsp_valid),
                (k == 7) ? 64'h4 : ((k >= 8 && k < 13) ? 64'h2 : 64'h0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
